// File: rtl/mmu_pkg.sv
// Shared definitions for the mmu datapath: feeder FSM states and fixed-point helpers.
// The sequencer state and the index counters both use these.
package mmu_pkg;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        COMPUTE = 3'd2,
        CAPTURE = 3'd3,
        RESULT  = 3'd4
    } feeder_state_t;

    localparam int DEFAULT_FIXED_PNT = 8;
    localparam int ONE = 1 << DEFAULT_FIXED_PNT;

    function automatic int fixedOne(input int fixedPnt);
        return 1 << fixedPnt;
    endfunction

    // Index counters never drop below one bit, so a dimension of 1 still gets a usable register.
    function automatic int idxWidth(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_deser_cnt.sv
// Row-major row/col index counter for deserialising one matrix.
// It wraps to 0 after the last element and flags the first and last positions.
module mat_deser_cnt
    import mmu_pkg::*;
#(
    parameter  int ROWS  = 1,
    parameter  int COLS  = 1,
    localparam int ROW_W = idxWidth(ROWS),
    localparam int COL_W = idxWidth(COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             first_o,
    output logic             last_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (adv_i) begin
            if (col_q == COL_W'(COLS - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o   = row_q;
    assign col_o   = col_q;
    assign first_o = (row_q == '0) && (col_q == '0);
    assign last_o  = (row_q == ROW_W'(ROWS - 1)) && (col_q == COL_W'(COLS - 1));

endmodule

// File: rtl/mmu_feeder.sv
// Sequencer in front of the mmu: loads A and B from an element stream, runs the mmu,
// captures its result into the accumulator and presents that as the result matrix.
module mmu_feeder
    import mmu_pkg::*;
#(
    parameter int NUM_ROWS_A = 1,
    parameter int NUM_COLS_A = 1,
    parameter int NUM_COLS_B = 1,
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [DATA_WIDTH-1:0]                                 in_data,
    input  logic                                                  accum_en,
    output logic                                                  mmu_enable,
    output logic [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0] mmu_mat_in1,
    output logic [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_in2,
    output logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_in_accum,
    input  logic                                                  mmu_data_ready,
    input  logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_out,
    output logic                                                  res_valid,
    input  logic                                                  res_ready,
    output logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] res_mat
);

    localparam int AR_W = idxWidth(NUM_ROWS_A);
    localparam int AC_W = idxWidth(NUM_COLS_A);
    localparam int BR_W = idxWidth(NUM_COLS_A);
    localparam int BC_W = idxWidth(NUM_COLS_B);

    feeder_state_t state_q, state_d;
    logic [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0] aMat_q, aMat_d;
    logic [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] bMat_q, bMat_d;
    logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] accum_q, accum_d;

    logic [AR_W-1:0] aRow;
    logic [AC_W-1:0] aCol;
    logic [BR_W-1:0] bRow;
    logic [BC_W-1:0] bCol;
    logic            aFirst, aLast, bFirst, bLast;
    logic            beat, aAdv, bAdv;

    assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign beat     = in_valid && in_ready;
    assign aAdv     = beat && (state_q == LOAD_A);
    assign bAdv     = beat && (state_q == LOAD_B);

    mat_deser_cnt #(.ROWS(NUM_ROWS_A), .COLS(NUM_COLS_A)) uACnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (aAdv),
        .row_o   (aRow),
        .col_o   (aCol),
        .first_o (aFirst),
        .last_o  (aLast)
    );

    mat_deser_cnt #(.ROWS(NUM_COLS_A), .COLS(NUM_COLS_B)) uBCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (bAdv),
        .row_o   (bRow),
        .col_o   (bCol),
        .first_o (bFirst),
        .last_o  (bLast)
    );

    // Operand and accumulator registers only move while loading or capturing, so they hold through COMPUTE.
    always_comb begin
        state_d = state_q;
        aMat_d  = aMat_q;
        bMat_d  = bMat_q;
        accum_d = accum_q;
        case (state_q)
            LOAD_A: begin
                if (aAdv) begin
                    for (int r = 0; r < NUM_ROWS_A; r++)
                        for (int c = 0; c < NUM_COLS_A; c++)
                            if (aRow == AR_W'(r) && aCol == AC_W'(c))
                                aMat_d[r][c] = in_data;
                    if (aFirst && !accum_en)
                        accum_d = '0;
                    if (aLast)
                        state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (bAdv) begin
                    for (int r = 0; r < NUM_COLS_A; r++)
                        for (int c = 0; c < NUM_COLS_B; c++)
                            if (bRow == BR_W'(r) && bCol == BC_W'(c))
                                bMat_d[r][c] = in_data;
                    if (bLast)
                        state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (mmu_data_ready)
                    state_d = CAPTURE;
            end
            // The mmu result settles the cycle after its ready pulse, which is this state.
            CAPTURE: begin
                accum_d = mmu_mat_out;
                state_d = RESULT;
            end
            RESULT: begin
                if (res_ready)
                    state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            aMat_q  <= '0;
            bMat_q  <= '0;
            accum_q <= '0;
        end else begin
            state_q <= state_d;
            aMat_q  <= aMat_d;
            bMat_q  <= bMat_d;
            accum_q <= accum_d;
        end
    end

    assign mmu_enable       = (state_q == COMPUTE);
    assign res_valid        = (state_q == RESULT);
    assign mmu_mat_in1      = aMat_q;
    assign mmu_mat_in2      = bMat_q;
    assign mmu_mat_in_accum = accum_q;
    assign res_mat          = accum_q;

endmodule

// File: tb/tb_mmu_feeder.sv
// Bench for mmu_feeder at 2x2x2 with a behavioural mmu and a job-level scoreboard
// checking handshake timing, operand stability, results and reset behaviour.
module tb_mmu_feeder;
    import mmu_pkg::*;

    localparam int W  = 16;
    localparam int FP = 8;

    typedef logic [1:0][1:0][W-1:0] mat_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         accum_en;
    logic         mmu_enable;
    mat_t         mmu_mat_in1;
    mat_t         mmu_mat_in2;
    mat_t         mmu_mat_in_accum;
    logic         mmu_data_ready = 1'b0;
    mat_t         mmu_mat_out = '0;
    logic         res_valid;
    logic         res_ready;
    mat_t         res_mat;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    mmu_feeder #(
        .NUM_ROWS_A (2),
        .NUM_COLS_A (2),
        .NUM_COLS_B (2),
        .DATA_WIDTH (W),
        .FIXED_PNT  (FP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .accum_en         (accum_en),
        .mmu_enable       (mmu_enable),
        .mmu_mat_in1      (mmu_mat_in1),
        .mmu_mat_in2      (mmu_mat_in2),
        .mmu_mat_in_accum (mmu_mat_in_accum),
        .mmu_data_ready   (mmu_data_ready),
        .mmu_mat_out      (mmu_mat_out),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_mat          (res_mat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-point product plus accumulator, wrapping to the element width.
    function automatic mat_t mmuRef(input mat_t a, input mat_t b, input mat_t acc);
        mat_t   r;
        longint s;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += longint'($signed(a[i][k])) * longint'($signed(b[k][j]));
                r[i][j] = acc[i][j] + W'(s >>> FP);
            end
        return r;
    endfunction

    function automatic mat_t mk(input logic [W-1:0] e00, input logic [W-1:0] e01,
                                input logic [W-1:0] e10, input logic [W-1:0] e11);
        mat_t m;
        m[0][0] = e00; m[0][1] = e01; m[1][0] = e10; m[1][1] = e11;
        return m;
    endfunction

    // Behavioural mmu: rising edge of enable starts a one-cycle compute; result lands with the cycle after the pulse.
    logic enQ = 1'b0;
    always @(posedge clk) begin
        enQ            <= mmu_enable;
        mmu_data_ready <= mmu_enable && !enQ;
        if (mmu_enable && !enQ)
            mmu_mat_out <= mmuRef(mmu_mat_in1, mmu_mat_in2, mmu_mat_in_accum);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Job-level model state
    bit   pending    = 1'b0;
    int   lastCyc    = 0;
    mat_t expA, expB, expAccIn, expRes;
    mat_t modelAccum = '0;
    bit   loading    = 1'b0;
    bit   earlyEn    = 1'b0;
    bit   prevEn     = 1'b0;
    bit   drSeen     = 1'b0;
    int   lowCount   = 99;

    // d counts cycles since the edge that took the last B beat; d=0 is the first enable cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            lowCount = 99;
            prevEn   = 1'b0;
            drSeen   = 1'b0;
        end else begin
            int d;
            bit expEn, expRv;
            d     = pending ? cyc - lastCyc : -1;
            expEn = pending && (d == 0 || d == 1);
            expRv = pending && (d >= 3);
            check("mmu_enable", mmu_enable, expEn);
            check("res_valid", res_valid, expRv);
            check("in_ready", in_ready, !pending);
            if (expEn) begin
                check("mmu_mat_in1", mmu_mat_in1, expA);
                check("mmu_mat_in2", mmu_mat_in2, expB);
                check("mmu_mat_in_accum", mmu_mat_in_accum, expAccIn);
            end
            if (expRv)
                check("res_mat", res_mat, expRes);
            if (expRv && res_ready)
                pending = 1'b0;
            if (mmu_enable && !prevEn) begin
                check("hs_low_gap", lowCount >= 2, 1'b1);
                drSeen = 1'b0;
            end
            if (mmu_enable && mmu_data_ready)
                drSeen = 1'b1;
            if (!mmu_enable && prevEn)
                check("hs_drop_after_ready", drSeen, 1'b1);
            lowCount = mmu_enable ? 0 : lowCount + 1;
            prevEn   = mmu_enable;
            if (loading && mmu_enable)
                earlyEn = 1'b1;
        end
    end

    task automatic sendBeat(input logic [W-1:0] d, input logic ae, input int gap);
        bit rdy;
        int n;
        n = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        accum_en = ae;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        if (!rdy)
            check("beat_timeout", rdy, 1'b1);
        #1;
        in_valid = 1'b0;
    endtask

    // accum_en is deliberately flipped after the first beat, since only the first beat may sample it.
    task automatic applyStimulus(input mat_t a, input mat_t b, input logic ae, input int gap);
        logic [W-1:0] beats [8];
        int n;
        n = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) beats[n++] = a[i][j];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) beats[n++] = b[i][j];
        loading = 1'b1;
        earlyEn = 1'b0;
        for (int k = 0; k < 8; k++)
            sendBeat(beats[k], (k == 0) ? ae : !ae, (k == 0) ? 0 : gap);
        loading  = 1'b0;
        expA     = a;
        expB     = b;
        expAccIn = ae ? modelAccum : '0;
        expRes   = mmuRef(a, b, expAccIn);
        modelAccum = expRes;
        lastCyc  = cyc;
        pending  = 1'b1;
    endtask

    task automatic awaitResult(output mat_t got, output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 40);
        if (!res_valid)
            check("result_timeout", res_valid, 1'b1);
        got = res_mat;
        lat = cyc - lastCyc;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (pending && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (pending) begin
            check("idle_timeout", pending, 1'b0);
            pending = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input mat_t got, input mat_t want);
        check(name, got, want);
    endtask

    initial begin
        mat_t identA, bBase, aBp, got, held;
        int   lat;
        identA = mk(16'(ONE), 16'h0000, 16'h0000, 16'(ONE));
        bBase  = mk(16'h0200, 16'h0300, 16'h0100, 16'h0080);
        aBp    = mk(16'h0100, 16'h0100, 16'h0000, 16'h0200);

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; accum_en = 1'b0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_mmu_enable", mmu_enable, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_mat_in1", mmu_mat_in1, '0);
        check("rst_mat_in2", mmu_mat_in2, '0);
        check("rst_accum", mmu_mat_in_accum, '0);
        check("rst_res_mat", res_mat, '0);
        @(posedge clk);
        #1;

        // Identity job: result equals B, res_valid in the 4th cycle after the last-beat cycle
        applyStimulus(identA, bBase, 1'b0, 0);
        awaitResult(got, lat);
        check("id_latency", lat, 3);
        checkOutput("id_res_mat", got, mk(16'h0200, 16'h0300, 16'h0100, 16'h0080));
        waitIdle();

        applyStimulus(identA, bBase, 1'b1, 0);
        awaitResult(got, lat);
        checkOutput("acc_res_mat", got, mk(16'h0400, 16'h0600, 16'h0200, 16'h0100));
        waitIdle();

        applyStimulus(identA, bBase, 1'b0, 0);
        awaitResult(got, lat);
        checkOutput("clr_res_mat", got, mk(16'h0200, 16'h0300, 16'h0100, 16'h0080));
        waitIdle();

        // Backpressure: result must hold for 5 cycles, then in_ready returns the cycle after acceptance
        res_ready = 1'b0;
        applyStimulus(aBp, bBase, 1'b0, 0);
        awaitResult(held, lat);
        checkOutput("bp_res_mat", held, mk(16'h0300, 16'h0380, 16'h0200, 16'h0100));
        repeat (5) begin
            @(negedge clk);
            check("bp_res_valid", res_valid, 1'b1);
            check("bp_res_hold", res_mat, held);
            check("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_ready_after_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Sparse input: one beat every third cycle, accumulating on the previous result
        applyStimulus(identA, bBase, 1'b1, 2);
        check("gap_no_early_enable", earlyEn, 1'b0);
        awaitResult(got, lat);
        checkOutput("gap_res_mat", got, mk(16'h0500, 16'h0680, 16'h0300, 16'h0180));
        waitIdle();

        // Reset during COMPUTE discards the job and clears the accumulator
        applyStimulus(aBp, bBase, 1'b0, 0);
        rst_n      = 1'b0;
        pending    = 1'b0;
        modelAccum = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rstc_mmu_enable", mmu_enable, 1'b0);
        check("rstc_res_valid", res_valid, 1'b0);
        check("rstc_accum", mmu_mat_in_accum, '0);
        check("rstc_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        applyStimulus(identA, bBase, 1'b1, 0);
        awaitResult(got, lat);
        checkOutput("post_rst_res_mat", got, mk(16'h0200, 16'h0300, 16'h0100, 16'h0080));
        waitIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", fails);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
